// File: rtl/pos_decode_dispatch.sv
// Binary position -> held one-hot strobe, fed from a small FIFO; strobe held until ack or timeout.
// Latency: push into an empty idle block shows out_valid two cycles later; 1 entry/cycle with ack held.
// Backpressure: in_ready drops while the FIFO holds DEPTH entries, with no write-through on a same-cycle pop.
module pos_decode_dispatch #(
    parameter int WIDTH   = 8,
    parameter int IDX_W   = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_pos,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_onehot,
    input  logic                     out_ack,
    output logic                     timeout_err,
    output logic                     range_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       mem_q [DEPTH];
    logic [IDX_W-1:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [IDX_W-1:0]       pos_q, pos_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   range_err_q, range_err_d;

    logic full, push, in_range, store, has_entry;
    logic ack_done, to_fire, release_entry, pop;

    always_comb begin
        full          = (count_q == CNT_W'(DEPTH));
        push          = in_valid && !full;
        in_range      = (32'(in_pos) < WIDTH);
        store         = push && in_range;
        has_entry     = (count_q != '0);
        ack_done      = (state_q == HOLD) && out_ack;
        // Ack takes priority: a timeout only fires on a cycle without ack.
        to_fire       = (state_q == HOLD) && !out_ack && (TIMEOUT != 0)
                        && (timer_q == TIMER_W'(TIMEOUT - 1));
        release_entry = ack_done || to_fire;
        pop           = has_entry && ((state_q == IDLE) || release_entry);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = HOLD;
            HOLD:    if (release_entry) state_d = has_entry ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO, held position and hold timer
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pos_d         = pos_q;
        timer_d       = timer_q;
        count_d       = count_q + CNT_W'(store) - CNT_W'(pop);
        timeout_err_d = to_fire;
        range_err_d   = push && !in_range;
        if (store) begin
            mem_d[wr_ptr_q] = in_pos;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            pos_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            timer_d  = '0;
        end else if (state_q == HOLD && !release_entry && timer_q != '1) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // Outputs
    always_comb begin
        in_ready    = !full;
        out_valid   = (state_q == HOLD);
        out_onehot  = out_valid ? ({{(WIDTH-1){1'b0}}, 1'b1} << pos_q) : '0;
        timeout_err = timeout_err_q;
        range_err   = range_err_q;
        fifo_count  = count_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pos_q         <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            range_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pos_q         <= pos_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            range_err_q   <= range_err_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_pos_decode_dispatch.sv
// Scoreboarded bench for pos_decode_dispatch: directed scenarios followed by random traffic.
module tb_pos_decode_dispatch;
    localparam int WIDTH   = 8;
    localparam int IDX_W   = 3;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   in_valid;
    logic                   in_ready;
    logic [IDX_W-1:0]       in_pos;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_onehot;
    logic                   out_ack;
    logic                   timeout_err;
    logic                   range_err;
    logic [$clog2(DEPTH):0] fifo_count;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    bit exp_to = 1'b0;
    int hold_cnt = 0;

    always #5 clk = ~clk;

    pos_decode_dispatch #(.WIDTH(WIDTH), .IDX_W(IDX_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos),
        .out_valid(out_valid), .out_onehot(out_onehot), .out_ack(out_ack),
        .timeout_err(timeout_err), .range_err(range_err), .fifo_count(fifo_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; an accepted push is recorded in the scoreboard.
    task automatic drive(input bit v, input int p, input bit a);
        in_valid = v;
        in_pos   = IDX_W'(p);
        out_ack  = a;
        if (v && in_ready && resetn) exp_q.push_back(p);
        step();
    endtask

    task automatic drain();
        int n = 0;
        while ((out_valid || fifo_count != 0) && n < 30) begin
            drive(0, 0, 1);
            n++;
        end
        chk("drain_bound", n < 30, 1);
    endtask

    // Monitor: entries leave in FIFO order on ack, or after TIMEOUT unacked held cycles.
    always @(negedge clk) begin
        int pend;
        if (!resetn) begin
            hold_cnt = 0;
            exp_to   = 1'b0;
        end else begin
            pend = (in_valid && in_ready) ? 1 : 0;
            chk("timeout_err", timeout_err, exp_to);
            exp_to = 1'b0;
            chk("range_err", range_err, 0);
            chk("outstanding", fifo_count + out_valid, exp_q.size() - pend);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    chk("out_onehot", out_onehot, 64'(1) << exp_q[0]);
                    if (out_ack) begin
                        void'(exp_q.pop_front());
                        hold_cnt = 0;
                    end else begin
                        hold_cnt++;
                        if (hold_cnt == TIMEOUT) begin
                            void'(exp_q.pop_front());
                            hold_cnt = 0;
                            exp_to   = 1'b1;
                        end
                    end
                end
            end else begin
                chk("onehot_idle", out_onehot, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[6];
        int idx, held, pulses, n, any_valid;
        bit acc;

        resetn = 1'b0; in_valid = 1'b0; in_pos = '0; out_ack = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_onehot", out_onehot, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_range", range_err, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single decode: valid exactly two cycles after the push
        drive(1, 5, 0);
        chk("single_k1_valid", out_valid, 0);
        drive(0, 0, 0);
        chk("single_k2_valid", out_valid, 1);
        chk("single_k2_onehot", out_onehot, 8'b0010_0000);
        drive(0, 0, 0);
        chk("single_k3_valid", out_valid, 1);
        drive(0, 0, 1);
        chk("single_after_ack", out_valid, 0);

        // Streaming with ack held: one-hot walks with no bubbles
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, i, 1);
            if (i >= 1 && i <= 8) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_onehot", out_onehot, 64'(1) << (i - 1));
            end
            if (i == 9) chk("stream_end_valid", out_valid, 0);
            chk("stream_count_le1", fifo_count <= 1, 1);
        end

        // Full: 1 held + 4 queued, 6th stalled until one ack
        vals = '{1, 3, 5, 7, 2, 4};
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            acc = in_ready;
            drive(1, vals[idx], 0);
            if (acc && idx < 5) idx++;
        end
        chk("full_accepted", idx, 5);
        chk("full_count", fifo_count, DEPTH);
        chk("full_in_ready", in_ready, 0);
        chk("full_held", out_valid, 1);
        drive(1, vals[5], 1);
        chk("full_ack_in_ready", in_ready, 1);
        chk("full_ack_count", fifo_count, DEPTH - 1);
        drive(1, vals[5], 0);
        chk("full_refill_count", fifo_count, DEPTH);
        in_valid = 1'b0;
        drain();

        // Timeout without ack
        drive(1, 2, 0);
        held = 0; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0);
            held += out_valid;
            pulses += timeout_err;
        end
        chk("timeout_held_cycles", held, TIMEOUT);
        chk("timeout_pulses", pulses, 1);

        // Ack on the last allowed cycle suppresses the timeout
        drive(1, 3, 0);
        n = 0;
        while (!out_valid && n < 5) begin
            drive(0, 0, 0);
            n++;
        end
        chk("late_ack_valid_seen", out_valid, 1);
        repeat (TIMEOUT - 1) drive(0, 0, 0);
        chk("late_ack_still_held", out_valid, 1);
        drive(0, 0, 1);
        chk("late_ack_released", out_valid, 0);
        chk("late_ack_no_timeout", timeout_err, 0);
        drive(0, 0, 0);
        chk("late_ack_no_timeout2", timeout_err, 0);

        // Reset mid-hold with 3 queued entries
        drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0); drive(1, 4, 0);
        in_valid = 1'b0;
        chk("midrst_count", fifo_count, 3);
        chk("midrst_held", out_valid, 1);
        resetn = 1'b0;
        exp_q.delete();
        step();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count0", fifo_count, 0);
        resetn = 1'b1;
        any_valid = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 1);
            any_valid += out_valid;
        end
        chk("midrst_no_stale", any_valid, 0);

        // Random traffic, alternating eager and lazy consumers
        for (int seg = 0; seg < 6; seg++) begin
            int ackp = (seg % 2) ? 50 : 4;
            for (int c = 0; c < 400; c++)
                drive($urandom_range(99) < 60, $urandom_range(WIDTH - 1), $urandom_range(99) < ackp);
        end
        in_valid = 1'b0;
        drain();
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
